vector_writeback_buffer: RTL and testbench



---
 rtl/vector_writeback_buffer_if.sv | 54 +++++
 rtl/vector_writeback_buffer.sv | 137 +++++++++++++
 tb/tb_vector_writeback_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_writeback_buffer_if.sv
// vector_writeback_buffer_if
//
// Bundles the three sides of the writeback buffer:
//   result_*     execution unit -> buffer, valid/ready handshake carrying a completed vd
//   vrf_write_*  buffer -> vector register file write port, valid/ready handshake
//   query_*      issue-stage pending-write lookup (combinational)
//
// Modports:
//   slave   the writeback buffer itself
//   master  the surroundings (execution units, VRF, issue stage) or a testbench
//
// vrf_write_sew64 carries the head entry's element width so a later VRF stage can apply
// tail masking; byte enables are full-register for now.

interface vector_writeback_buffer_if #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned REG_INDEX_WIDTH = 5
);
    logic                       result_valid;
    logic                       result_ready;
    logic [REG_INDEX_WIDTH-1:0] result_index;
    logic                       result_sew64;
    logic [VLEN-1:0]            result_data;

    logic                       vrf_write_valid;
    logic                       vrf_write_ready;
    logic [REG_INDEX_WIDTH-1:0] vrf_write_index;
    logic [VLEN-1:0]            vrf_write_data;
    logic [VLEN/8-1:0]          vrf_write_byte_enable;
    logic                       vrf_write_sew64;

    logic [REG_INDEX_WIDTH-1:0] query_index;
    logic                       query_hit;

    modport slave (
        input  result_valid, result_index, result_sew64, result_data,
        output result_ready,
        output vrf_write_valid, vrf_write_index, vrf_write_data, vrf_write_byte_enable,
        output vrf_write_sew64,
        input  vrf_write_ready,
        input  query_index,
        output query_hit
    );

    modport master (
        output result_valid, result_index, result_sew64, result_data,
        input  result_ready,
        input  vrf_write_valid, vrf_write_index, vrf_write_data, vrf_write_byte_enable,
        input  vrf_write_sew64,
        output vrf_write_ready,
        output query_index,
        input  query_hit
    );
endinterface

// File: rtl/vector_writeback_buffer.sv
// vector_writeback_buffer
//
// In-order buffer between the vector functional units' vd outputs and the VRF write port.
// Completed results are accepted with a valid/ready handshake, held in a DEPTH-entry circular
// FIFO and drained to the VRF in acceptance order. A combinational pending-write query lets
// the issue stage stall on a source register that still has a write in flight.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high; discards all buffered results
//   bus     vector_writeback_buffer_if.slave (result_*, vrf_write_*, query_*)
//
// Optional feature (macro WRITEBACK_BYPASS_EN):
//   defined   when the buffer is empty, an incoming result is routed straight to the VRF port
//             in the same cycle; if the VRF takes it, it is never enqueued
//   undefined every result passes through storage (1-cycle minimum latency)

module vector_writeback_buffer #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned REG_INDEX_WIDTH = 5
) (
    input logic                      clock,
    input logic                      reset,
    vector_writeback_buffer_if.slave bus
);
    localparam int unsigned       PtrWidth  = $clog2(DEPTH);
    localparam logic [PtrWidth:0] CountFull = (PtrWidth + 1)'(DEPTH);

    logic [PtrWidth-1:0]        write_pointer_q, write_pointer_d;
    logic [PtrWidth-1:0]        read_pointer_q, read_pointer_d;
    logic [PtrWidth:0]          count_q, count_d;
    logic [DEPTH-1:0]           occupied_q, occupied_d;

    logic [REG_INDEX_WIDTH-1:0] index_q [DEPTH];
    logic [VLEN-1:0]            data_q  [DEPTH];
    logic [DEPTH-1:0]           sew64_q;

    logic not_empty;
    logic not_full;
    logic enqueue;
    logic dequeue;
    logic bypass_fire;
    logic query_hit_c;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CountFull);

    // A full buffer refuses input even if the head leaves this cycle.
    assign bus.result_ready = !reset && not_full;

`ifdef WRITEBACK_BYPASS_EN
    logic bypass_route;

    // Route the incoming result to the VRF port only while nothing older is waiting.
    assign bypass_route        = !reset && !not_empty && bus.result_valid;
    assign bypass_fire         = bypass_route && bus.vrf_write_ready;
    assign bus.vrf_write_valid = !reset && (not_empty || bus.result_valid);
    assign bus.vrf_write_index = bypass_route ? bus.result_index : index_q[read_pointer_q];
    assign bus.vrf_write_data  = bypass_route ? bus.result_data  : data_q[read_pointer_q];
    assign bus.vrf_write_sew64 = bypass_route ? bus.result_sew64 : sew64_q[read_pointer_q];
`else
    assign bypass_fire         = 1'b0;
    assign bus.vrf_write_valid = !reset && not_empty;
    assign bus.vrf_write_index = index_q[read_pointer_q];
    assign bus.vrf_write_data  = data_q[read_pointer_q];
    assign bus.vrf_write_sew64 = sew64_q[read_pointer_q];
`endif

    // Full-register write for both element widths.
    assign bus.vrf_write_byte_enable = bus.vrf_write_valid ? '1 : '0;

    // A bypassed result goes straight out and must not also be stored.
    assign enqueue = bus.result_valid && bus.result_ready && !bypass_fire;
    assign dequeue = not_empty && bus.vrf_write_valid && bus.vrf_write_ready;

    // Occupied flags track stored entries only, so a result being enqueued this cycle does not
    // hit while the head being written this cycle still does.
    always_comb begin
        query_hit_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied_q[i] && (index_q[i] == bus.query_index)) begin
                query_hit_c = 1'b1;
            end
        end
    end

    assign bus.query_hit = query_hit_c;

    always_comb begin
        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        count_d         = count_q;
        occupied_d      = occupied_q;

        // Pointers are power-of-two wide, so the increment wraps modulo DEPTH on its own.
        if (enqueue) begin
            write_pointer_d             = write_pointer_q + PtrWidth'(1);
            occupied_d[write_pointer_q] = 1'b1;
        end
        if (dequeue) begin
            read_pointer_d             = read_pointer_q + PtrWidth'(1);
            occupied_d[read_pointer_q] = 1'b0;
        end

        case ({enqueue, dequeue})
            2'b10:   count_d = count_q + (PtrWidth + 1)'(1);
            2'b01:   count_d = count_q - (PtrWidth + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pointer_q <= '0;
            read_pointer_q  <= '0;
            count_q         <= '0;
            occupied_q      <= '0;
            sew64_q         <= '0;
            // Clearing storage keeps the VRF-facing index/data at zero out of reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                index_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            write_pointer_q <= write_pointer_d;
            read_pointer_q  <= read_pointer_d;
            count_q         <= count_d;
            occupied_q      <= occupied_d;
            if (enqueue) begin
                index_q[write_pointer_q] <= bus.result_index;
                data_q[write_pointer_q]  <= bus.result_data;
                sew64_q[write_pointer_q] <= bus.result_sew64;
            end
        end
    end
endmodule

// File: tb/tb_vector_writeback_buffer.sv
// tb_vector_writeback_buffer
//
// Drives the buffer through directed scenarios and a randomized phase. Every cycle the DUT's
// outputs are compared, just before the rising edge, with a reference model that holds the
// buffered results as a plain queue of {index, data} in acceptance order.

module tb_vector_writeback_buffer;
    localparam int unsigned VLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RIW   = 5;

    typedef struct {
        logic [RIW-1:0]  index;
        logic [VLEN-1:0] data;
    } wb_entry_t;

    logic clock;
    logic reset;

    vector_writeback_buffer_if #(.VLEN(VLEN), .REG_INDEX_WIDTH(RIW)) bus ();

    vector_writeback_buffer #(
        .VLEN            (VLEN),
        .DEPTH           (DEPTH),
        .REG_INDEX_WIDTH (RIW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wb_entry_t model_q[$];
    int        n_tests;
    int        n_failed;
    int        n_written;
    logic      last_accept;

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Compare outputs against the model, then apply this edge's handshakes to the model.
    task automatic evaluate();
        wb_entry_t head;
        logic      exp_ready;
        logic      exp_valid;
        logic      exp_hit;
        logic      bypass;
        logic      popped;

        head.index = '0;
        head.data  = '0;
        bypass     = 1'b0;
        exp_ready  = !reset && (model_q.size() < DEPTH);
        exp_valid  = !reset && (model_q.size() != 0);
        if (exp_valid) head = model_q[0];
`ifdef WRITEBACK_BYPASS_EN
        if (!reset && model_q.size() == 0 && bus.result_valid) begin
            exp_valid  = 1'b1;
            head.index = bus.result_index;
            head.data  = bus.result_data;
            bypass     = bus.vrf_write_ready;
        end
`endif
        exp_hit = 1'b0;
        foreach (model_q[i]) begin
            if (model_q[i].index == bus.query_index) exp_hit = 1'b1;
        end

        check_value("result_ready", 64'(bus.result_ready), 64'(exp_ready));
        check_value("vrf_write_valid", 64'(bus.vrf_write_valid), 64'(exp_valid));
        check_value("query_hit", 64'(bus.query_hit), 64'(exp_hit));
        if (exp_valid) begin
            check_value("vrf_write_index", 64'(bus.vrf_write_index), 64'(head.index));
            check_value("vrf_write_data", 64'(bus.vrf_write_data), 64'(head.data));
            check_value("vrf_write_byte_enable", 64'(bus.vrf_write_byte_enable), 64'hFF);
        end

        last_accept = bus.result_valid && exp_ready && !bypass;
        popped      = exp_valid && bus.vrf_write_ready && !bypass;
        if (reset) begin
            model_q.delete();
        end else begin
            if (bypass) n_written++;
            if (popped) begin
                void'(model_q.pop_front());
                n_written++;
            end
            if (last_accept) begin
                wb_entry_t e;
                e.index = bus.result_index;
                e.data  = bus.result_data;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        evaluate();
        @(posedge clock);
        #1;
    endtask

    task automatic set_result(input logic [RIW-1:0] idx, input logic [VLEN-1:0] data);
        bus.result_valid = 1'b1;
        bus.result_index = idx;
        bus.result_data  = data;
        bus.result_sew64 = idx[0];
    endtask

    // Hold a result until the model says it was accepted, with a cycle budget.
    task automatic push(input logic [RIW-1:0] idx, input logic [VLEN-1:0] data);
        int budget;
        budget = 50;
        set_result(idx, data);
        last_accept = 1'b0;
        while (!last_accept && budget > 0) begin
            cycle();
            budget--;
        end
        check_value("push_accepted", 64'(last_accept), 64'd1);
        bus.result_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 50;
        bus.result_valid    = 1'b0;
        bus.vrf_write_ready = 1'b1;
        while (model_q.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        cycle();
        check_value("drain_idle", 64'(bus.vrf_write_valid), 64'd0);
    endtask

    function automatic logic [VLEN-1:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int base;
        int sent;
        int cyc;

        n_tests   = 0;
        n_failed  = 0;
        n_written = 0;
        reset               = 1'b1;
        bus.result_valid    = 1'b0;
        bus.result_index    = '0;
        bus.result_sew64    = 1'b0;
        bus.result_data     = '0;
        bus.vrf_write_ready = 1'b0;
        bus.query_index     = '0;

        // Reset state.
        @(posedge clock);
        #1;
        cycle();
        reset = 1'b0;
        #1;
        check_value("rst_ready", 64'(bus.result_ready), 64'd1);
        check_value("rst_valid", 64'(bus.vrf_write_valid), 64'd0);
        check_value("rst_index", 64'(bus.vrf_write_index), 64'd0);
        check_value("rst_data", 64'(bus.vrf_write_data), 64'd0);
        check_value("rst_byte_enable", 64'(bus.vrf_write_byte_enable), 64'd0);
        check_value("rst_query_hit", 64'(bus.query_hit), 64'd0);
        cycle();

        // Single result, VRF ready.
        bus.vrf_write_ready = 1'b1;
        base = n_written;
        push(5'd5, 64'h0123_4567_89AB_CDEF);
        drain();
        check_value("single_written", 64'(n_written - base), 64'd1);

        // Stalled VRF fills the buffer; the 5th result waits for the first dequeue.
        bus.vrf_write_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(RIW'(i), rand_data());
        set_result(5'd5, rand_data());
        repeat (3) cycle();
        check_value("full_ready", 64'(bus.result_ready), 64'd0);
        bus.vrf_write_ready = 1'b1;
        cycle();
        check_value("full_pop_refuses_push", 64'(last_accept), 64'd0);
        cycle();
        check_value("push_after_pop", 64'(last_accept), 64'd1);
        bus.result_valid = 1'b0;
        drain();

        // Query: 7 and 9 buffered.
        bus.vrf_write_ready = 1'b0;
        push(5'd7, rand_data());
        push(5'd9, rand_data());
        bus.query_index = 5'd7;
        cycle();
        bus.query_index = 5'd8;
        cycle();
        bus.query_index = 5'd9;
        cycle();
        bus.query_index     = 5'd7;
        bus.vrf_write_ready = 1'b1;
        cycle();
        bus.vrf_write_ready = 1'b0;
        check_value("query_hit_after_pop", 64'(bus.query_hit), 64'd0);
        cycle();
        drain();

        // Reset mid-drain discards buffered results.
        bus.vrf_write_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(RIW'(10 + i), rand_data());
        reset = 1'b1;
        cycle();
        reset               = 1'b0;
        bus.vrf_write_ready = 1'b1;
        #1;
        check_value("mid_drain_valid", 64'(bus.vrf_write_valid), 64'd0);
        check_value("mid_drain_ready", 64'(bus.result_ready), 64'd1);
        repeat (3) cycle();

        // Pointer wrap: 10 back-to-back results, VRF ready every other cycle.
        base = n_written;
        sent = 0;
        cyc  = 0;
        set_result(RIW'(sent), rand_data());
        while (sent < 10 && cyc < 200) begin
            bus.vrf_write_ready = cyc[0];
            cycle();
            cyc++;
            if (last_accept) begin
                sent++;
                set_result(RIW'(sent), rand_data());
            end
        end
        bus.result_valid = 1'b0;
        check_value("wrap_sent", 64'(sent), 64'd10);
        drain();
        check_value("wrap_written", 64'(n_written - base), 64'd10);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset               = ($urandom_range(0, 49) == 0);
            bus.result_valid    = $urandom_range(0, 1);
            bus.result_index    = RIW'($urandom_range(0, 7));
            bus.result_sew64    = $urandom_range(0, 1);
            bus.result_data     = rand_data();
            bus.vrf_write_ready = ($urandom_range(0, 2) != 0);
            bus.query_index     = RIW'($urandom_range(0, 7));
            cycle();
        end
        reset = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
